ysyx_25040111_memresp: RTL and testbench
========================================

Name: ysyx_25040111_memresp

Overview:
Read responder on the memory side of the cache refill interface. Accepts a one-cycle `rstart` pulse with an address and issues one word read on a simple request/grant SRAM-style backend port. It returns the word with a one-cycle `rok` pulse, after an optional programmable extra latency. Out-of-range addresses return an error instead of accessing memory; a one-entry skid buffer absorbs back-to-back requests.

Parameters:
- LATENCY, 0, extra wait cycles inserted before the backend request (0..255)
- BASE, 32'h8000_0000, first mapped byte address
- SIZE_Ls, 24, log2 of mapped region size in bytes

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- rstart  in  1  one-cycle read request pulse from the cache
- raddr  in  32  request address, sampled when rstart=1
- rok  out  1  one-cycle response pulse
- rdata  out  32  response word, valid only when rok=1
- rerr  out  1  response error flag, valid when rok=1
- ovf  out  1  sticky: a request was dropped; cleared only by reset
- mem_req  out  1  backend request
- mem_addr  out  32  backend word address, bits [1:0] forced to 0
- mem_gnt  in  1  backend grant; handshake completes when mem_req&mem_gnt
- mem_rvalid  in  1  backend read data valid, earliest 1 cycle after grant
- mem_rdata  in  32  backend read data

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; rok=0, rdata=0, rerr=0, ovf=0, mem_req=0, mem_addr=0.
  - Latency counter=0; skid buffer empty.
- States:
  - IDLE: on rstart, latch raddr into cur_addr. Go to WAIT if LATENCY>0, else REQ.
  - WAIT: counter loads LATENCY-1 on entry and decrements each cycle. At 0, go to REQ.
  - REQ:
    - If cur_addr is out of range, no memory access; go to DONE with err=1 and data=0.
    - Otherwise hold mem_req=1 and mem_addr={cur_addr[31:2],2'b00} until mem_gnt, then go to RESP.
  - RESP: wait for mem_rvalid. Register mem_rdata into rdata and go to DONE.
  - DONE: rok=1 for exactly one cycle with rdata/rerr. Next state:
    - skid full: pop the skid into cur_addr and go to WAIT/REQ directly (no IDLE bubble);
    - skid empty: go to IDLE.
- Range check: in range iff (cur_addr - BASE) < 2**SIZE_Ls, unsigned 32-bit compare. The wrap-around below BASE must fail the check.
- Minimum latency with LATENCY=0, gnt and rvalid at earliest:
  - rstart at T, mem_req at T+1, gnt at T+1, rvalid at T+2, rok at T+3.
  - Each LATENCY cycle adds one to this.
- Out-of-range minimum: rok with rerr=1 at T+2 (LATENCY=0).
- rstart while not IDLE: stored in the skid if the skid is empty.
- rstart while the skid is full: request dropped and ovf<=1.
- rstart in the same cycle as a DONE pop: the new request goes into the freed skid slot (no drop).
- rdata and rerr hold their last values after rok falls. The cache samples them only when rok=1.
- mem_rvalid outside RESP is ignored (covers a stale response after reset).
- Reset mid-transaction abandons everything: no rok, mem_req drops immediately.

Decomposition:
- Shared package/header:
  - state encoding localparams (IDLE, WAIT, REQ, RESP, DONE, 3 bits);
  - the width of the cache request/response interface (32).
- One natural sub-module: ysyx_25040111_memresp_skid, a one-entry address buffer with push, pop, full and ovf.

Test Plan:
- LATENCY=0, rstart raddr=0x8000_0010, gnt immediate, rvalid next cycle with 0xDEADBEEF -> mem_addr=0x8000_0010; rok at T+3, rdata=0xDEADBEEF, rerr=0.
- LATENCY=4, same request -> mem_req first asserted at T+5; rok at T+7.
- raddr=0x7FFF_FFFC and raddr=0x8100_0000 (SIZE_Ls=24) -> mem_req never asserted; rok with rerr=1, rdata=0.
- Three rstart pulses on consecutive cycles, gnt held low 5 cycles -> first two served in order (two rok pulses, matching data); third dropped; ovf=1.
- rstart exactly on the DONE cycle of a prior request -> both served, ovf stays 0.
- Reset asserted during RESP, then rvalid=1 after release -> rok never pulses; state IDLE; a fresh request then completes normally.

Source files
------------

// File: rtl/ysyx_25040111_memresp_pkg.sv
// rtl/ysyx_25040111_memresp_pkg.sv - shared encodings for the refill read responder
package ysyx_25040111_memresp_pkg;

  localparam int IF_W = 32;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_REQ  = 3'd2,
    S_RESP = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // Offset compare so that addresses below base wrap to huge offsets and fail.
  function automatic logic addr_in_range(input logic [IF_W-1:0] addr,
                                         input logic [IF_W-1:0] base,
                                         input int              size_log2);
    logic [IF_W-1:0] off;
    off = addr - base;
    return {1'b0, off} < (33'd1 << size_log2);
  endfunction

endpackage

// File: rtl/ysyx_25040111_memresp_skid.sv
// rtl/ysyx_25040111_memresp_skid.sv - one-entry address skid buffer with sticky overflow
module ysyx_25040111_memresp_skid
  import ysyx_25040111_memresp_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [IF_W-1:0] din,
  output logic [IF_W-1:0] dout,
  output logic            full,
  output logic            ovf
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dout <= '0;
      full <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      // A push coinciding with a pop reuses the slot being freed.
      if (push && (!full || pop)) begin
        dout <= din;
        full <= 1'b1;
      end else if (pop) begin
        full <= 1'b0;
      end
      if (push && full && !pop) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ysyx_25040111_memresp.sv
// rtl/ysyx_25040111_memresp.sv - memory-side read responder for cache refills
module ysyx_25040111_memresp
  import ysyx_25040111_memresp_pkg::*;
#(
  parameter int          LATENCY = 0,
  parameter logic [31:0] BASE    = 32'h8000_0000,
  parameter int          SIZE_Ls = 24
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rstart,
  input  logic [31:0] raddr,
  output logic        rok,
  output logic [31:0] rdata,
  output logic        rerr,
  output logic        ovf,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam logic [7:0] LAT_LOAD = (LATENCY > 0) ? 8'(LATENCY - 1) : 8'd0;

  state_t          state;
  logic [IF_W-1:0] cur_addr;
  logic [7:0]      cnt;
  logic            skid_full;
  logic            skid_push;
  logic            skid_pop;
  logic [IF_W-1:0] skid_addr;
  logic            launch;
  logic [IF_W-1:0] launch_addr;

  // Next address to serve: a fresh pulse in IDLE, or from DONE the skid entry
  // first, falling back to a same-cycle pulse so DONE never needs an IDLE bubble.
  always_comb begin
    launch      = 1'b0;
    launch_addr = raddr;
    case (state)
      S_IDLE: launch = rstart;
      S_DONE: begin
        launch = skid_full | rstart;
        if (skid_full) begin
          launch_addr = skid_addr;
        end
      end
      default: launch = 1'b0;
    endcase
  end

  assign skid_pop  = (state == S_DONE) && skid_full;
  assign skid_push = rstart && (state != S_IDLE) &&
                     !((state == S_DONE) && !skid_full);

  ysyx_25040111_memresp_skid u_skid (
    .clock (clock),
    .reset (reset),
    .push  (skid_push),
    .pop   (skid_pop),
    .din   (raddr),
    .dout  (skid_addr),
    .full  (skid_full),
    .ovf   (ovf)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      cur_addr <= '0;
      cnt      <= 8'd0;
      rok      <= 1'b0;
      rdata    <= '0;
      rerr     <= 1'b0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
    end else begin
      rok <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (launch) begin
            cur_addr <= launch_addr;
            if (LATENCY > 0) begin
              state <= S_WAIT;
              cnt   <= LAT_LOAD;
            end else begin
              state    <= S_REQ;
              mem_req  <= addr_in_range(launch_addr, BASE, SIZE_Ls);
              mem_addr <= {launch_addr[31:2], 2'b00};
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (cnt == 8'd0) begin
            state    <= S_REQ;
            mem_req  <= addr_in_range(cur_addr, BASE, SIZE_Ls);
            mem_addr <= {cur_addr[31:2], 2'b00};
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        S_REQ: begin
          // mem_req low on REQ entry means the range check already failed.
          if (!mem_req) begin
            state <= S_DONE;
            rok   <= 1'b1;
            rerr  <= 1'b1;
            rdata <= '0;
          end else if (mem_gnt) begin
            mem_req <= 1'b0;
            state   <= S_RESP;
          end
        end
        S_RESP: begin
          if (mem_rvalid) begin
            state <= S_DONE;
            rok   <= 1'b1;
            rerr  <= 1'b0;
            rdata <= mem_rdata;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25040111_memresp.sv
// tb/tb_ysyx_25040111_memresp.sv - self-checking bench for the refill read responder
module tb_ysyx_25040111_memresp;

  localparam logic [31:0] BASE    = 32'h8000_0000;
  localparam int          SIZE_LS = 24;

  logic        clock = 1'b0;
  logic        reset;
  logic        rstart;
  logic [31:0] raddr;
  logic [1:0]  rok, rerr, ovf, mem_req, gnt, rvalid;
  logic [31:0] rdata    [2];
  logic [31:0] mem_addr [2];
  logic [31:0] mrdata   [2];

  int errors = 0;
  int checks = 0;
  bit rnd_mode = 1'b0;
  bit rv_inject = 1'b0;
  int gnt_wait = 0;
  int rv_dly_cfg = 0;
  int rok0_q[$];
  int rok1_q[$];
  int fr0, fr1;

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] memfn(input logic [31:0] wa);
    if (wa == 32'h8000_0010) return 32'hDEAD_BEEF;
    return wa ^ 32'h3C5A_96E1;
  endfunction

  // {err, data} the cache should see for a request to address a.
  function automatic logic [32:0] expect_of(input logic [31:0] a);
    if (64'(a) >= 64'(BASE) && 64'(a) < 64'(BASE) + (64'd1 << SIZE_LS))
      return {1'b0, memfn({a[31:2], 2'b00})};
    return {1'b1, 32'h0};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gd
    ysyx_25040111_memresp #(.LATENCY(g * 4), .BASE(BASE), .SIZE_Ls(SIZE_LS)) u (
      .clock      (clock),
      .reset      (reset),
      .rstart     (rstart),
      .raddr      (raddr),
      .rok        (rok[g]),
      .rdata      (rdata[g]),
      .rerr       (rerr[g]),
      .ovf        (ovf[g]),
      .mem_req    (mem_req[g]),
      .mem_addr   (mem_addr[g]),
      .mem_gnt    (gnt[g]),
      .mem_rvalid (rvalid[g]),
      .mem_rdata  (mrdata[g])
    );

    int          req_cyc = 0;
    bit          pend = 1'b0;
    int          dly = 0;
    logic [31:0] laddr = '0;
    bit          rv_r = 1'b0;
    logic [31:0] rd_r = '0;
    bit          grnd = 1'b0;

    assign gnt[g]    = mem_req[g] && (rnd_mode ? grnd : (req_cyc >= gnt_wait));
    assign rvalid[g] = rv_r | rv_inject;
    assign mrdata[g] = rv_inject ? 32'hBAD0_BAD0 : rd_r;

    always @(posedge clock) begin : backend
      int d;
      rv_r    <= 1'b0;
      grnd    <= ($urandom_range(0, 1) == 1);
      req_cyc <= (mem_req[g] && !gnt[g]) ? req_cyc + 1 : 0;
      if (pend) begin
        if (dly == 0) begin
          rv_r <= 1'b1;
          rd_r <= memfn(laddr);
          pend <= 1'b0;
        end else begin
          dly <= dly - 1;
        end
      end
      if (mem_req[g] && gnt[g]) begin
        check($sformatf("dut%0d_mem_addr_align", g), mem_addr[g][1:0], 2'b00);
        d = rnd_mode ? int'($urandom_range(0, 3)) : rv_dly_cfg;
        if (d == 0) begin
          rv_r <= 1'b1;
          rd_r <= memfn(mem_addr[g]);
        end else begin
          pend  <= 1'b1;
          dly   <= d - 1;
          laddr <= mem_addr[g];
        end
      end
    end

    // Reference: up to two requests held (one in service, one buffered); a
    // response leaving this cycle frees its place for a same-cycle request.
    logic [32:0] q[$];
    int occ = 0;
    bit eovf = 1'b0;
    int nrok = 0;

    always @(negedge clock) begin
      if (!reset) begin
        q.delete();
        occ  = 0;
        eovf = 1'b0;
      end else begin
        if (rok[g]) begin
          nrok++;
          check($sformatf("dut%0d_rok_expected", g), q.size() > 0, 1'b1);
          if (q.size() > 0) begin
            check($sformatf("dut%0d_resp", g), {rerr[g], rdata[g]}, q.pop_front());
          end
          if (occ > 0) occ--;
        end
        if (rstart) begin
          if (occ < 2) begin
            q.push_back(expect_of(raddr));
            occ++;
          end else begin
            eovf = 1'b1;
          end
        end
      end
    end
  end

  task automatic run_seq(input logic [31:0] starts, input logic [31:0] addr0, input int ncyc);
    rok0_q.delete();
    rok1_q.delete();
    fr0 = -1;
    fr1 = -1;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clock);
      #1;
      rstart = starts[c];
      raddr  = addr0 + 32'(c * 16);
      @(negedge clock);
      if (rok[0]) rok0_q.push_back(c);
      if (rok[1]) rok1_q.push_back(c);
      if (mem_req[0] && fr0 < 0) fr0 = c;
      if (mem_req[1] && fr1 < 0) fr1 = c;
    end
    rstart = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    @(posedge clock);
    #1 reset = 1'b1;
  endtask

  typedef struct {
    logic [31:0] addr;
    int          gw;
    int          req0, req4, lat0, lat4;
    logic        err;
    logic [31:0] data;
  } vec_t;

  vec_t vt[8];
  int   e0[3];
  int   e1[3];
  int   s0, s1;

  initial begin
    rstart = 1'b0;
    raddr  = '0;
    reset  = 1'b0;

    vt[0] = '{32'h8000_0010, 0, 1, 5, 3, 7, 1'b0, 32'hDEAD_BEEF};
    vt[1] = '{32'h8000_0013, 0, 1, 5, 3, 7, 1'b0, 32'hDEAD_BEEF};
    vt[2] = '{32'h8000_0000, 2, 1, 5, 5, 9, 1'b0, 32'hBC5A_96E1};
    vt[3] = '{32'h80FF_FFFC, 0, 1, 5, 3, 7, 1'b0, 32'hBCA5_691D};
    vt[4] = '{32'h7FFF_FFFC, 0, -1, -1, 2, 6, 1'b1, 32'h0};
    vt[5] = '{32'h8100_0000, 0, -1, -1, 2, 6, 1'b1, 32'h0};
    vt[6] = '{32'h0000_0000, 0, -1, -1, 2, 6, 1'b1, 32'h0};
    vt[7] = '{32'hFFFF_FFFC, 0, -1, -1, 2, 6, 1'b1, 32'h0};

    repeat (3) @(posedge clock);
    @(negedge clock);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("reset_rok%0d", g), rok[g], 1'b0);
      check($sformatf("reset_rdata%0d", g), rdata[g], 32'h0);
      check($sformatf("reset_rerr%0d", g), rerr[g], 1'b0);
      check($sformatf("reset_ovf%0d", g), ovf[g], 1'b0);
      check($sformatf("reset_mem_req%0d", g), mem_req[g], 1'b0);
      check($sformatf("reset_mem_addr%0d", g), mem_addr[g], 32'h0);
    end
    @(posedge clock);
    #1 reset = 1'b1;

    for (int i = 0; i < 8; i++) begin
      gnt_wait = vt[i].gw;
      run_seq(32'h1, vt[i].addr, 14);
      check($sformatf("vec%0d_first_req0", i), fr0, vt[i].req0);
      check($sformatf("vec%0d_first_req4", i), fr1, vt[i].req4);
      check($sformatf("vec%0d_rok0_cycle", i), rok0_q.size() == 1 ? rok0_q[0] : -1, vt[i].lat0);
      check($sformatf("vec%0d_rok4_cycle", i), rok1_q.size() == 1 ? rok1_q[0] : -1, vt[i].lat4);
      check($sformatf("vec%0d_rdata0_held", i), rdata[0], vt[i].data);
      check($sformatf("vec%0d_rerr0_held", i), rerr[0], vt[i].err);
      check($sformatf("vec%0d_rdata4_held", i), rdata[1], vt[i].data);
      check($sformatf("vec%0d_rerr4_held", i), rerr[1], vt[i].err);
    end

    // Three back-to-back pulses while the backend stalls: third is dropped.
    gnt_wait = 5;
    s0 = gd[0].nrok;
    s1 = gd[1].nrok;
    run_seq(32'b111, 32'h8000_0100, 30);
    check("b2b_nrok0", gd[0].nrok - s0, 2);
    check("b2b_nrok4", gd[1].nrok - s1, 2);
    check("b2b_ovf0", ovf[0], 1'b1);
    check("b2b_ovf4", ovf[1], 1'b1);
    e0 = '{8, 16, -1};
    for (int k = 0; k < 2; k++)
      check($sformatf("b2b_rok0_cycle%0d", k), k < rok0_q.size() ? rok0_q[k] : -1, e0[k]);
    pulse_reset();
    check("ovf_cleared0", ovf[0], 1'b0);
    check("ovf_cleared4", ovf[1], 1'b0);

    // Pulse on DONE while the skid is full: pop and push in the same cycle.
    gnt_wait = 0;
    run_seq(32'b1011, 32'h8000_0200, 30);
    e0 = '{3, 6, 9};
    for (int k = 0; k < 3; k++)
      check($sformatf("done_pop_rok0_cycle%0d", k), k < rok0_q.size() ? rok0_q[k] : -1, e0[k]);
    check("done_pop_ovf0", ovf[0], 1'b0);
    check("done_pop_ovf4", ovf[1], gd[1].eovf);
    check("done_pop_rok4_n", rok1_q.size(), 2);
    pulse_reset();

    // Pulse on DONE with the skid empty: served directly without a bubble.
    run_seq(32'b1001, 32'h8000_0300, 24);
    e0 = '{3, 6, -1};
    e1 = '{7, 14, -1};
    for (int k = 0; k < 2; k++) begin
      check($sformatf("done_direct_rok0_cycle%0d", k), k < rok0_q.size() ? rok0_q[k] : -1, e0[k]);
      check($sformatf("done_direct_rok4_cycle%0d", k), k < rok1_q.size() ? rok1_q[k] : -1, e1[k]);
    end
    check("done_direct_ovf0", ovf[0], 1'b0);
    check("done_direct_ovf4", ovf[1], 1'b0);

    // Reset in mid-transaction followed by stale read data.
    rv_dly_cfg = 6;
    @(posedge clock);
    #1 rstart = 1'b1;
    raddr = 32'h8000_0400;
    @(posedge clock);
    #1 rstart = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    check("midrst_req4_before", mem_req[1], 1'b1);
    reset = 1'b0;
    #1;
    check("midrst_req4_dropped", mem_req[1], 1'b0);
    check("midrst_req0_low", mem_req[0], 1'b0);
    @(negedge clock);
    @(posedge clock);
    #1 reset = 1'b1;
    rv_inject = 1'b1;
    s0 = gd[0].nrok;
    s1 = gd[1].nrok;
    repeat (2) @(posedge clock);
    #1 rv_inject = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    check("midrst_no_rok0", gd[0].nrok - s0, 0);
    check("midrst_no_rok4", gd[1].nrok - s1, 0);
    check("midrst_idle_req0", mem_req[0], 1'b0);
    check("midrst_idle_req4", mem_req[1], 1'b0);
    rv_dly_cfg = 0;
    run_seq(32'h1, 32'h8000_0010, 14);
    check("after_rst_rok0_cycle", rok0_q.size() == 1 ? rok0_q[0] : -1, 3);
    check("after_rst_rok4_cycle", rok1_q.size() == 1 ? rok1_q[0] : -1, 7);
    check("after_rst_rdata0", rdata[0], 32'hDEAD_BEEF);

    // Randomised traffic against the reference model.
    rnd_mode = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(posedge clock);
      #1;
      rstart = ($urandom_range(0, 99) < 35);
      case ($urandom_range(0, 3))
        0:       raddr = BASE + ($urandom & 32'h00FF_FFFF);
        1:       raddr = BASE - $urandom_range(1, 64);
        2:       raddr = BASE + 32'h0100_0000 - $urandom_range(0, 8);
        default: raddr = $urandom;
      endcase
    end
    @(posedge clock);
    #1 rstart = 1'b0;
    repeat (80) @(posedge clock);
    rnd_mode = 1'b0;
    #1;
    check("rand_drained0", gd[0].q.size(), 0);
    check("rand_drained4", gd[1].q.size(), 0);
    check("rand_ovf0", ovf[0], gd[0].eovf);
    check("rand_ovf4", ovf[1], gd[1].eovf);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
